// File: rtl/conv_sequencer.sv
// conv_sequencer: address/strobe sequencer for one 2-D valid convolution.
// Walks every output window and issues one kernel tap per cycle.
// It then waits out the MAC latency and hands the result off with valid/ready.
// Optional performance counter: define CONV_SEQ_PERF_CNT_EN to enable cycle_count.
// All outputs are registered from next-state values, so they track the state
// of the same cycle without an extra cycle of lag.
module conv_sequencer #(
  parameter int IMG_DIM     = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_SIZE   = 4,
  parameter int KADDR_SIZE  = 4,
  parameter int OADDR_SIZE  = 2,
  parameter int MAC_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_SIZE-1:0]  img_addr,
  output logic [KADDR_SIZE-1:0] krn_addr,
  output logic                  mac_en,
  output logic                  acc_first,
  output logic                  acc_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OADDR_SIZE-1:0] out_addr,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           cycle_count
);

  localparam int OD = IMG_DIM - KERNEL_SIZE + 1;
  localparam int CW = 8;
  localparam logic [CW-1:0] K_LAST   = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] OD_LAST  = CW'(OD - 1);
  localparam logic [CW-1:0] W_LAST   = CW'(OD * OD - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAC  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] orow_q, orow_d, ocol_q, ocol_d;
  logic [CW-1:0] kr_q, kr_d, kc_q, kc_d;
  logic [CW-1:0] w_q, w_d, wcnt_q, wcnt_d;

  logic [ADDR_SIZE-1:0]  img_addr_q, img_addr_d;
  logic [KADDR_SIZE-1:0] krn_addr_q, krn_addr_d;
  logic [OADDR_SIZE-1:0] out_addr_q, out_addr_d;
  logic mac_en_q, mac_en_d, acc_first_q, acc_first_d, acc_last_q, acc_last_d;
  logic out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;

  // Next state and window/tap/latency counters; abort overrides everything.
  always_comb begin
    state_d = state_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    w_d     = w_q;
    wcnt_d  = wcnt_q;
    if (abort) begin
      state_d = S_IDLE;
      orow_d  = '0;
      ocol_d  = '0;
      kr_d    = '0;
      kc_d    = '0;
      w_d     = '0;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_MAC;
            orow_d  = '0;
            ocol_d  = '0;
            kr_d    = '0;
            kc_d    = '0;
            w_d     = '0;
            wcnt_d  = '0;
          end
        end
        S_MAC: begin
          if (kc_q == K_LAST) begin
            kc_d = '0;
            if (kr_q == K_LAST) begin
              kr_d    = '0;
              wcnt_d  = '0;
              state_d = (MAC_LAT == 0) ? S_OUT : S_WAIT;
            end else begin
              kr_d = kr_q + 1'b1;
            end
          end else begin
            kc_d = kc_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (wcnt_q == LAT_LAST) begin
            wcnt_d  = '0;
            state_d = S_OUT;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        S_OUT: begin
          if (out_valid_q && out_ready) begin
            if (w_q == W_LAST) begin
              state_d = S_DONE;
              orow_d  = '0;
              ocol_d  = '0;
              w_d     = '0;
            end else begin
              state_d = S_MAC;
              w_d     = w_q + 1'b1;
              if (ocol_q == OD_LAST) begin
                ocol_d = '0;
                orow_d = orow_q + 1'b1;
              end else begin
                ocol_d = ocol_q + 1'b1;
              end
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output values decoded from the next state so they register in step with it.
  always_comb begin
    mac_en_d    = (state_d == S_MAC);
    img_addr_d  = '0;
    krn_addr_d  = '0;
    acc_first_d = 1'b0;
    acc_last_d  = 1'b0;
    if (mac_en_d) begin
      img_addr_d  = ADDR_SIZE'((32'(orow_d) + 32'(kr_d)) * IMG_DIM + 32'(ocol_d) + 32'(kc_d));
      krn_addr_d  = KADDR_SIZE'(32'(kr_d) * KERNEL_SIZE + 32'(kc_d));
      acc_first_d = (kr_d == '0) && (kc_d == '0);
      acc_last_d  = (kr_d == K_LAST) && (kc_d == K_LAST);
    end
    out_valid_d = (state_d == S_OUT);
    out_addr_d  = out_valid_d ? OADDR_SIZE'(w_d) : '0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      orow_q      <= '0;
      ocol_q      <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      w_q         <= '0;
      wcnt_q      <= '0;
      img_addr_q  <= '0;
      krn_addr_q  <= '0;
      mac_en_q    <= 1'b0;
      acc_first_q <= 1'b0;
      acc_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      orow_q      <= orow_d;
      ocol_q      <= ocol_d;
      kr_q        <= kr_d;
      kc_q        <= kc_d;
      w_q         <= w_d;
      wcnt_q      <= wcnt_d;
      img_addr_q  <= img_addr_d;
      krn_addr_q  <= krn_addr_d;
      mac_en_q    <= mac_en_d;
      acc_first_q <= acc_first_d;
      acc_last_q  <= acc_last_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign img_addr  = img_addr_q;
  assign krn_addr  = krn_addr_q;
  assign mac_en    = mac_en_q;
  assign acc_first = acc_first_q;
  assign acc_last  = acc_last_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CONV_SEQ_PERF_CNT_EN
  logic [15:0] cycle_count_q, cycle_count_d;

  // Busy-cycle counter: clears on start acceptance, saturates, holds on abort.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (!abort) begin
      if (state_q == S_IDLE && start)
        cycle_count_d = '0;
      else if (busy_q && cycle_count_q != 16'hFFFF)
        cycle_count_d = cycle_count_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_count_q <= '0;
    else     cycle_count_q <= cycle_count_d;
  end

  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Testbench for conv_sequencer: each scenario task drives stimulus and checks
// the outputs every cycle against expectations from the window/tap rules.
module tb_conv_sequencer;

  localparam int IMG_DIM = 4;
  localparam int KS      = 3;
  localparam int ML      = 2;
  localparam int OD      = IMG_DIM - KS + 1;
  localparam int NW      = OD * OD;
  localparam int KK      = KS * KS;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [3:0]  img_addr, krn_addr;
  logic [1:0]  out_addr;
  logic        mac_en, acc_first, acc_last, out_valid, busy, done;
  logic [15:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  conv_sequencer #(
    .IMG_DIM(IMG_DIM), .KERNEL_SIZE(KS), .ADDR_SIZE(4), .KADDR_SIZE(4),
    .OADDR_SIZE(2), .MAC_LAT(ML)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .img_addr(img_addr), .krn_addr(krn_addr), .mac_en(mac_en),
    .acc_first(acc_first), .acc_last(acc_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .busy(busy), .done(done),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Packed view of all outputs; out_addr only matters while out_valid is high.
  function automatic logic [15:0] obs_vec();
    return {img_addr, krn_addr, mac_en, acc_first, acc_last, out_valid,
            (out_valid ? out_addr : 2'b00), busy, done};
  endfunction

  task automatic step(input bit noise);
    @(negedge clk);
    cyc++;
    if (noise) begin
      start     = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      start     = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (obs_vec() !== 16'h0000 || cycle_count !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_async: got %h/%h want 0000/0000", obs_vec(), cycle_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs_vec() !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want 0000", obs_vec());
    end
  endtask

  // mode 0: ready always high; mode 1: 5-cycle stall at window 2;
  // mode 2: random ready and random start noise throughout the run.
  task automatic test_run_traffic(input int mode);
    logic [15:0] exp;
    int stalls, stalls_total, done_cyc, orow, ocol, exp_cc;
    bit rdy, hs;
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; abort = 1'b0; cyc = 0;
    stalls_total = 0;
    for (int w = 0; w < NW; w++) begin
      orow = w / OD;
      ocol = w % OD;
      for (int t = 0; t < KK; t++) begin
        step(mode == 2);
        exp = {4'((orow + t / KS) * IMG_DIM + ocol + t % KS), 4'(t), 1'b1,
               1'(t == 0), 1'(t == KK - 1), 1'b0, 2'b00, 1'b1, 1'b0};
        n_cmp++;
        if (obs_vec() !== exp) begin
          n_bad++;
          $display("FAIL tap m%0d w%0d t%0d cyc%0d: got %h want %h", mode, w, t, cyc, obs_vec(), exp);
        end
      end
      for (int l = 0; l < ML; l++) begin
        step(mode == 2);
        n_cmp++;
        if (obs_vec() !== 16'h0002) begin
          n_bad++;
          $display("FAIL wait m%0d w%0d cyc%0d: got %h want 0002", mode, w, cyc, obs_vec());
        end
      end
      stalls = 0;
      hs = 1'b0;
      for (int s = 0; s < 64 && !hs; s++) begin
        step(mode == 2);
        exp = {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'(w), 1'b1, 1'b0};
        n_cmp++;
        if (obs_vec() !== exp) begin
          n_bad++;
          $display("FAIL out m%0d w%0d cyc%0d: got %h want %h", mode, w, cyc, obs_vec(), exp);
        end
        if (mode == 1)      rdy = !(w == 2 && stalls < 5);
        else if (mode == 2) rdy = 1'($urandom_range(0, 1));
        else                rdy = 1'b1;
        out_ready = rdy;
        if (rdy) hs = 1'b1;
        else     stalls++;
      end
      if (!hs) begin
        n_cmp++; n_bad++;
        $display("FAIL handshake_timeout m%0d w%0d: got no handshake want handshake", mode, w);
        abort = 1'b1; step(1'b0); abort = 1'b0;
        return;
      end
      stalls_total += stalls;
    end
    step(mode == 2);
    done_cyc = cyc;
    n_cmp++;
    if (obs_vec() !== 16'h0003) begin
      n_bad++;
      $display("FAIL done m%0d cyc%0d: got %h want 0003", mode, cyc, obs_vec());
    end
    @(negedge clk); cyc++;
    start = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (obs_vec() !== 16'h0000) begin
      n_bad++;
      $display("FAIL idle_after m%0d: got %h want 0000", mode, obs_vec());
    end
    n_cmp++;
    if (done_cyc !== 1 + NW * (KK + ML + 1) + stalls_total) begin
      n_bad++;
      $display("FAIL done_cycle m%0d: got %0d want %0d", mode, done_cyc, 1 + NW * (KK + ML + 1) + stalls_total);
    end
`ifdef CONV_SEQ_PERF_CNT_EN
    exp_cc = done_cyc;
`else
    exp_cc = 0;
`endif
    n_cmp++;
    if (cycle_count !== 16'(exp_cc)) begin
      n_bad++;
      $display("FAIL cycle_count m%0d: got %0d want %0d", mode, cycle_count, exp_cc);
    end
    step(1'b0);
    n_cmp++;
    if (obs_vec() !== 16'h0000) begin
      n_bad++;
      $display("FAIL no_restart m%0d: got %h want 0000", mode, obs_vec());
    end
  endtask

  task automatic test_abort();
    bit seen;
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; cyc = 0;
    while (cyc < 20) step(1'b0);
    // cycle 20 is tap 7 of window 1: kr=2, kc=1, ocol=1
    n_cmp++;
    if ({img_addr, krn_addr, mac_en} !== {4'd10, 4'd7, 1'b1}) begin
      n_bad++;
      $display("FAIL pre_abort_tap: got %h/%h/%b want a/7/1", img_addr, krn_addr, mac_en);
    end
    abort = 1'b1;
    step(1'b0);
    abort = 1'b0;
    n_cmp++;
    if (obs_vec() !== 16'h0000) begin
      n_bad++;
      $display("FAIL abort_idle cyc%0d: got %h want 0000", cyc, obs_vec());
    end
    seen = 1'b0;
    repeat (60) begin
      step(1'b0);
      if (done || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_done: got activity=%b want 0", seen);
    end
    @(negedge clk);
    start = 1'b1;
    step(1'b0);
    n_cmp++;
    if ({img_addr, krn_addr, mac_en, acc_first} !== {4'd0, 4'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL restart_tap0: got %h/%h/%b%b want 0/0/11", img_addr, krn_addr, mac_en, acc_first);
    end
    abort = 1'b1;
    step(1'b0);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort2_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; cyc = 0;
    repeat (10) step(1'b0);
    n_cmp++;
    if (obs_vec() !== 16'h0002) begin
      n_bad++;
      $display("FAIL wait_before_rst: got %h want 0002", obs_vec());
    end
    #2;
    rst = 1'b1;
    start = 1'b1;
    #1;
    n_cmp++;
    if (obs_vec() !== 16'h0000 || cycle_count !== 16'h0000) begin
      n_bad++;
      $display("FAIL async_rst: got %h/%h want 0000/0000", obs_vec(), cycle_count);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (3) begin
      step(1'b0);
      n_cmp++;
      if (obs_vec() !== 16'h0000) begin
        n_bad++;
        $display("FAIL post_rst_idle: got %h want 0000", obs_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_traffic(0);
    test_run_traffic(1);
    test_run_traffic(2);
    test_run_traffic(2);
    test_abort();
    test_async_reset();
    test_run_traffic(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
